// File: rtl/rega_pkg.sv
// Shared types and constants for the irrigation countdown sequencer.
// Latency: n/a (types, constants and the duration table only).
// Backpressure: n/a.
//
// Contents: FSM state enumeration, modo -> BCD duration preset table,
// display scan index constants.
package rega_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ARM   = 3'd2,
      ST_RUN   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_ABORT = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // BCD MM:SS duration, tens-of-minutes first.
   typedef struct packed {
      logic [3:0] dm;
      logic [3:0] um;
      logic [3:0] ds;
      logic [3:0] us;
   } preset_t;

   // Index is modo: 00:30, 02:00, 05:00, 10:00.
   localparam preset_t PRESET_TBL [0:3] = '{
      '{dm: 4'd0, um: 4'd0, ds: 4'd3, us: 4'd0},
      '{dm: 4'd0, um: 4'd2, ds: 4'd0, us: 4'd0},
      '{dm: 4'd0, um: 4'd5, ds: 4'd0, us: 4'd0},
      '{dm: 4'd1, um: 4'd0, ds: 4'd0, us: 4'd0}
   };

   // Display digit scan order.
   localparam logic [1:0] SEL_US = 2'd0;
   localparam logic [1:0] SEL_DS = 2'd1;
   localparam logic [1:0] SEL_UM = 2'd2;
   localparam logic [1:0] SEL_DM = 2'd3;

endpackage

// File: rtl/rega_tick_divider.sv
// Modulo-N counter with synchronous clear, hold enable and terminal-count pulse.
// Latency: tc_o high in the cycle the count equals N-1 while enabled.
// Backpressure: en_i low freezes the count in place; clr_i wins over en_i.
//
// Ports: clk_i/rst_n_i clock and async active-low reset; clr_i sync clear;
// en_i count enable; tc_o terminal-count pulse (decode of the count register).
module rega_tick_divider #(
   parameter int unsigned N = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rega_sequencer.sv
// Irrigation control FSM: start/load/arm/run/hold/abort/done plus display scan.
// Latency: start edge at N -> load at N+1, valve from N+3; stop/cancel act next cycle.
// Backpressure: none; dry=0 pauses counting, start edges while busy are dropped.
//
// Ports: new_clock_i/reset_n_i clock and async active-low reset; start_i,
// cancel_i, dry_i, modo_i, timer_stop_i control inputs; load_o/clear_o/
// count_tick_o/preset_*_o drive the BCD timer; seletor_o display scan;
// valve_o, busy_o, done_o status.
module rega_sequencer
   import rega_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned SCAN_DIV = 50_000
) (
   input  logic       new_clock_i,
   input  logic       reset_n_i,
   input  logic       start_i,
   input  logic       cancel_i,
   input  logic       dry_i,
   input  logic [1:0] modo_i,
   input  logic       timer_stop_i,
   output logic       load_o,
   output logic       clear_o,
   output logic [3:0] preset_us_o,
   output logic [3:0] preset_ds_o,
   output logic [3:0] preset_um_o,
   output logic [3:0] preset_dm_o,
   output logic       count_tick_o,
   output logic [1:0] seletor_o,
   output logic       valve_o,
   output logic       busy_o,
   output logic       done_o
);

   state_t     state_q, state_d;
   logic       start_q;
   preset_t    preset_q, preset_d;
   logic       load_q, load_d;
   logic       clear_q, clear_d;
   logic       done_q, done_d;
   logic       valve_q, valve_d;
   logic       busy_q, busy_d;
   logic [1:0] seletor_q, seletor_d;
   logic       tick_tc, scan_tc;

   // Count pulse divider: cleared while arming, runs only in RUN so that
   // HOLD freezes it and the resume continues from the same phase.
   rega_tick_divider #(.N(TICK_DIV)) u_tick_div (
      .clk_i   (new_clock_i),
      .rst_n_i (reset_n_i),
      .clr_i   (state_q == ST_ARM),
      .en_i    (state_q == ST_RUN),
      .tc_o    (tick_tc)
   );

   // Free-running display scan step.
   rega_tick_divider #(.N(SCAN_DIV)) u_scan_div (
      .clk_i   (new_clock_i),
      .rst_n_i (reset_n_i),
      .clr_i   (1'b0),
      .en_i    (1'b1),
      .tc_o    (scan_tc)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start_i && !start_q && dry_i) state_d = ST_LOAD;
         ST_LOAD:  state_d = cancel_i ? ST_ABORT : ST_ARM;
         ST_ARM:   state_d = cancel_i ? ST_ABORT : ST_RUN;
         ST_RUN: begin
            // The stop flag is ignored in a tick cycle: the timer has not
            // yet absorbed that tick, so its zero flag may be stale.
            if (cancel_i)                         state_d = ST_ABORT;
            else if (timer_stop_i && !tick_tc)    state_d = ST_DONE;
            else if (!dry_i)                      state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (cancel_i)   state_d = ST_ABORT;
            else if (dry_i) state_d = ST_RUN;
         end
         ST_ABORT: state_d = ST_IDLE;
         ST_DONE:  state_d = cancel_i ? ST_ABORT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      load_d  = (state_d == ST_LOAD);
      clear_d = (state_d == ST_ABORT);
      done_d  = (state_d == ST_DONE);
      valve_d = (state_d == ST_RUN);
      busy_d  = (state_d != ST_IDLE);

      preset_d = preset_q;
      if (state_q == ST_IDLE && state_d == ST_LOAD) begin
         preset_d = PRESET_TBL[modo_i];
      end

      seletor_d = seletor_q;
      if (scan_tc) begin
         seletor_d = (seletor_q == SEL_DM) ? SEL_US : seletor_q + 2'd1;
      end
   end

   always_ff @(posedge new_clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         preset_q  <= '0;
         load_q    <= 1'b0;
         clear_q   <= 1'b0;
         done_q    <= 1'b0;
         valve_q   <= 1'b0;
         busy_q    <= 1'b0;
         seletor_q <= SEL_US;
      end else begin
         state_q   <= state_d;
         start_q   <= start_i;
         preset_q  <= preset_d;
         load_q    <= load_d;
         clear_q   <= clear_d;
         done_q    <= done_d;
         valve_q   <= valve_d;
         busy_q    <= busy_d;
         seletor_q <= seletor_d;
      end
   end

   assign load_o       = load_q;
   assign clear_o      = clear_q;
   assign done_o       = done_q;
   assign valve_o      = valve_q;
   assign busy_o       = busy_q;
   assign seletor_o    = seletor_q;
   assign count_tick_o = tick_tc;
   assign preset_us_o  = preset_q.us;
   assign preset_ds_o  = preset_q.ds;
   assign preset_um_o  = preset_q.um;
   assign preset_dm_o  = preset_q.dm;

endmodule

// File: tb/tb_rega_sequencer.sv
// Self-checking bench for rega_sequencer with a behavioural countdown timer.
// Latency: n/a.
// Backpressure: n/a.
module tb_rega_sequencer;

   localparam int unsigned TICK = 4;
   localparam int unsigned SCAN = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       dry = 1'b0;
   logic [1:0] modo = 2'b00;
   logic       timer_stop;
   logic       load, clear, count_tick, valve, busy, done;
   logic [3:0] p_us, p_ds, p_um, p_dm;
   logic [1:0] seletor;

   rega_sequencer #(.TICK_DIV(TICK), .SCAN_DIV(SCAN)) dut (
      .new_clock_i  (clk),
      .reset_n_i    (reset_n),
      .start_i      (start),
      .cancel_i     (cancel),
      .dry_i        (dry),
      .modo_i       (modo),
      .timer_stop_i (timer_stop),
      .load_o       (load),
      .clear_o      (clear),
      .preset_us_o  (p_us),
      .preset_ds_o  (p_ds),
      .preset_um_o  (p_um),
      .preset_dm_o  (p_dm),
      .count_tick_o (count_tick),
      .seletor_o    (seletor),
      .valve_o      (valve),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   // Timer model: remaining time held as plain seconds.
   int tsec = 0;
   always @(posedge clk) begin
      if (clear)                       tsec <= 0;
      else if (load)                   tsec <= int'(p_dm) * 600 + int'(p_um) * 60 + int'(p_ds) * 10 + int'(p_us);
      else if (count_tick && tsec > 0) tsec <= tsec - 1;
   end
   assign timer_stop = (tsec == 0);

   // Event counters, only ever incremented here.
   int n_tick = 0, n_load = 0, n_clear = 0, n_done = 0, n_valve = 0;
   always @(posedge clk) begin
      if (count_tick) n_tick  <= n_tick + 1;
      if (load)       n_load  <= n_load + 1;
      if (clear)      n_clear <= n_clear + 1;
      if (done)       n_done  <= n_done + 1;
      if (valve)      n_valve <= n_valve + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int secs_of(input logic [1:0] m);
      case (m)
         2'd0:    return 30;
         2'd1:    return 120;
         2'd2:    return 300;
         default: return 600;
      endcase
   endfunction

   task automatic chk_presets(input string tag, input int s);
      chk({tag, "_us"}, 32'(p_us), 32'(s % 10));
      chk({tag, "_ds"}, 32'(p_ds), 32'((s % 60) / 10));
      chk({tag, "_um"}, 32'(p_um), 32'((s / 60) % 10));
      chk({tag, "_dm"}, 32'(p_dm), 32'(s / 600));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_load"},  32'(load), 0);
      chk({tag, "_clear"}, 32'(clear), 0);
      chk({tag, "_tick"},  32'(count_tick), 0);
      chk({tag, "_valve"}, 32'(valve), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_sel"},   32'(seletor), 0);
      chk_presets(tag, 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (done === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_ticks(input int target, input int base, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (n_tick - base >= target) ok = 1'b1;
      end
   endtask

   initial begin
      int   b_tick, b_load, b_clear, b_done, b_valve, t0, v0, s, k;
      logic ok;
      logic [1:0] m;

      // Reset
      #2 reset_n = 1'b0;
      dry  = 1'b1;
      modo = 2'b00;
      step();
      step();
      chk_all_zero("reset");
      reset_n = 1'b1;
      step();

      // Normal 00:30 run
      b_tick = n_tick; b_load = n_load; b_clear = n_clear; b_valve = n_valve;
      pulse_start();
      chk("t1_load", 32'(load), 1);
      chk("t1_busy", 32'(busy), 1);
      chk_presets("t1_preset", 30);
      step();
      chk("t1_load_once", 32'(load), 0);
      chk("t1_arm_valve", 32'(valve), 0);
      step();
      chk("t1_run_valve", 32'(valve), 1);
      wait_done(30 * TICK + 20, ok);
      chk("t1_done_seen", 32'(ok), 1);
      chk("t1_done_valve", 32'(valve), 0);
      chk("t1_ticks", 32'(n_tick - b_tick), 30);
      chk("t1_model_zero", 32'(tsec), 0);
      chk("t1_valve_cycles", 32'(n_valve - b_valve), 30 * TICK + 1);
      chk("t1_loads", 32'(n_load - b_load), 1);
      chk("t1_clears", 32'(n_clear - b_clear), 0);
      step();
      chk("t1_done_pulse", 32'(done), 0);
      chk("t1_idle_busy", 32'(busy), 0);

      // 10:00 run with a 10-cycle dry gap
      modo = 2'b11;
      b_tick = n_tick; b_valve = n_valve;
      pulse_start();
      chk_presets("t2_preset", 600);
      step();
      step();
      k = 50 + int'($urandom_range(0, 500));
      wait_ticks(k, b_tick, k * TICK + 20, ok);
      chk("t2_reach_gap", 32'(ok), 1);
      dry = 1'b0;
      step();
      chk("t2_hold_valve", 32'(valve), 0);
      chk("t2_hold_busy", 32'(busy), 1);
      t0 = n_tick;
      v0 = n_valve;
      repeat (9) step();
      chk("t2_gap_ticks", 32'(n_tick - t0), 0);
      chk("t2_gap_valve", 32'(n_valve - v0), 0);
      dry = 1'b1;
      wait_done(600 * TICK + 40, ok);
      chk("t2_done_seen", 32'(ok), 1);
      chk("t2_ticks", 32'(n_tick - b_tick), 600);
      chk("t2_valve_cycles", 32'(n_valve - b_valve), 600 * TICK + 1);
      chk("t2_model_zero", 32'(tsec), 0);
      step();

      // Cancel at tick 5 of a 02:00 run
      modo = 2'b01;
      b_tick = n_tick; b_done = n_done; b_clear = n_clear;
      pulse_start();
      wait_ticks(5, b_tick, 5 * TICK + 20, ok);
      chk("t3_reach_5", 32'(ok), 1);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("t3_clear", 32'(clear), 1);
      chk("t3_valve", 32'(valve), 0);
      chk("t3_busy_abort", 32'(busy), 1);
      step();
      chk("t3_busy_idle", 32'(busy), 0);
      chk("t3_clear_once", 32'(n_clear - b_clear), 1);
      chk("t3_model_zero", 32'(tsec), 0);
      chk("t3_no_done", 32'(n_done - b_done), 0);
      chk("t3_ticks", 32'(n_tick - b_tick), 5);

      // Start edge while wet is dropped, held level does not retrigger
      b_load = n_load;
      dry = 1'b0;
      start = 1'b1;
      step();
      chk("t4_wet_busy", 32'(busy), 0);
      chk("t4_wet_load", 32'(load), 0);
      repeat (3) step();
      dry = 1'b1;
      repeat (3) step();
      chk("t4_level_busy", 32'(busy), 0);
      chk("t4_level_loads", 32'(n_load - b_load), 0);
      start = 1'b0;
      step();

      // modo change and start re-pulse during RUN
      m = 2'($urandom_range(0, 1));
      s = secs_of(m);
      modo = m;
      b_tick = n_tick; b_load = n_load;
      pulse_start();
      step();
      step();
      repeat (10 + int'($urandom_range(0, 20))) step();
      modo = ~m;
      pulse_start();
      repeat (5) step();
      chk_presets("t5_preset", s);
      chk("t5_loads", 32'(n_load - b_load), 1);
      chk("t5_busy", 32'(busy), 1);
      wait_done(s * TICK + 20, ok);
      chk("t5_done_seen", 32'(ok), 1);
      chk("t5_ticks", 32'(n_tick - b_tick), 32'(s));
      step();

      // Asynchronous reset mid-RUN, then scan sequence
      modo = 2'($urandom_range(0, 3));
      pulse_start();
      repeat (3 + int'($urandom_range(0, 10))) step();
      chk("t6_running", 32'(valve), 1);
      #2 reset_n = 1'b0;
      #1;
      chk_all_zero("t6_rst");
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk($sformatf("t6_sel_%0d", i), 32'(seletor), 32'((i / 2) % 4));
      end
      chk("t6_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rega_sequencer.md
# rega_sequencer

Control FSM for the irrigation countdown timer (BCD MM:SS with per-digit preset/clear, zero-detect `stop`, 4-digit multiplexed 7-seg display). It decides when watering starts, loads the duration preset selected by `modo`, produces the 1 Hz count pulse that steps the timer down, and holds the valve open while counting. It pauses on wet soil, aborts on `cancel`, and drives the display digit scan `seletor`.

## Interface
- `TICK_DIV`, 50_000_000: `new_clock` cycles per count pulse (1 s); minimum 2.
- `SCAN_DIV`, 50_000: `new_clock` cycles per display digit step; minimum 1.
- `new_clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  start request; rising edge acts, level ignored.
- `cancel`  in  1  abort request, level-sensitive.
- `dry`  in  1  soil sensor; 1 = dry (watering needed).
- `modo`  in  2  duration select: 00 = 00:30, 01 = 02:00, 10 = 05:00, 11 = 10:00.
- `timer_stop`  in  1  timer zero flag (all digits 0).
- `load`  out  1  one-cycle pulse; the timer takes `preset_*`.
- `clear`  out  1  one-cycle pulse; the timer clears all digits.
- `preset_us`, `preset_ds`, `preset_um`, `preset_dm`  out  4 each  BCD duration digits, stable from LOAD until the next LOAD.
- `count_tick`  out  1  one-cycle count pulse to the timer.
- `seletor`  out  2  display digit select.
- `valve`  out  1  water valve drive.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, LOAD, ARM, RUN, HOLD, ABORT, DONE.
- IDLE → LOAD: on a `start` rising edge (registered previous value) with `dry`=1. An edge while `dry`=0 is dropped and not remembered.
- LOAD:
  - `load`=1 for one cycle.
  - `preset_*` are registered from `modo` on entry. `modo` changes after that are ignored until the next LOAD.
  - Next state is ARM.
- ARM: one settle cycle, then RUN. The tick divider is cleared to 0.
- RUN:
  - `valve`=1.
  - The divider counts 0..TICK_DIV-1. `count_tick`=1 in the cycle the count is TICK_DIV-1, then the count wraps to 0.
  - `timer_stop`=1 → DONE. The flag is sampled only in cycles where `count_tick`=0.
  - `dry`=0 → HOLD.
- HOLD:
  - `valve`=0, no `count_tick`, divider frozen at its current value.
  - `dry`=1 → RUN; the divider resumes from the frozen value.
- ABORT: `clear`=1 for one cycle, then IDLE.
- DONE: `done`=1 for one cycle, then IDLE. No `clear` is issued; the timer already reads 00:00.
- Priority within a cycle: `cancel` > `timer_stop` > `dry` > `start`.
  - `cancel`=1 in LOAD, ARM, RUN, HOLD or DONE forces ABORT.
  - `cancel` in IDLE has no effect.
- `start` edges while `busy`=1 are ignored.
- The scan counter is free-running in every state, independent of the FSM:
  - `seletor` increments every SCAN_DIV cycles and wraps 3→0.
  - 0 = US, 1 = DS, 2 = UM, 3 = DM.

## Timing
- Reset (asynchronous assert while `reset_n`=0): state IDLE; all outputs 0; divider, scan counter and start-edge register cleared.
- All outputs are registered; none depends combinationally on an input.
- `start` rising edge sampled at cycle N → `load`=1 in N+1, ARM in N+2, `valve`=1 from N+3.
- First `count_tick` comes TICK_DIV cycles after entering RUN.
- `timer_stop` high at cycle M (in RUN, no tick) → `valve`=0 and `done`=1 in M+1, IDLE in M+2.
- `cancel` at cycle M → `valve`=0 and `clear`=1 in M+1, IDLE in M+2.
- `dry` falling at cycle M → `valve`=0 in M+1.
- Total RUN+HOLD time spent in RUN equals the preset seconds × TICK_DIV, plus the cycles in which `timer_stop` is observed.

## Structure
- Package `rega_pkg`:
  - state enumeration;
  - `modo` → BCD preset constant table (US/DS/UM/DM per mode);
  - scan index constants.
- Sub-module `rega_tick_divider`: parameterised modulo-N counter with synchronous clear and hold enable, and a terminal-count pulse. Instantiated twice: once for the TICK_DIV count pulse, once for the SCAN_DIV scan step.
- The FSM and output registers live in `rega_sequencer`.

## Test plan
(Bench uses TICK_DIV=4, SCAN_DIV=2, and a behavioural BCD countdown model driven by `load`/`clear`/`count_tick`.)
- `modo`=00, `dry`=1, `start` edge → `load` once, presets 0/3/0/0; `valve` high for 30 ticks; `done` pulse one cycle after the model reaches zero; `valve`=0.
- `modo`=11 run, `dry`=0 for 10 cycles mid-RUN → `valve`=0 and no ticks during the gap; after resume, total tick count still 600.
- `cancel` asserted at tick 5 of `modo`=01 → `clear` pulse next cycle, `busy`=0 one cycle later, model reads 00:00, no `done`.
- `start` edge with `dry`=0 → no `load`, FSM stays IDLE; `start` held high, then `dry`=1 → still IDLE (no new edge).
- `modo` toggled and `start` re-pulsed during RUN → presets unchanged, no second `load`.
- `reset_n` low mid-RUN → all outputs 0 immediately; `seletor` cycles 0,1,2,3,0 every 2 cycles after release.
